// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: multi-cycle mult/multu/div/divu into HI/LO,
// plus mthi/mtlo writes and the mfhi/mflo read mux.
module e_mdu #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDUOp,
    input  logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDOut
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam int MAXC  = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               launch;
    logic               is_mul;
    logic [31:0]        res_hi, res_lo;
    logic [31:0]        hi_tmp, lo_tmp;

    // Signed 32x32 -> 64 product, returned as {hi, lo}.
    function automatic logic [63:0] mul_s(input logic signed [31:0] a,
                                          input logic signed [31:0] b);
        logic signed [63:0] ae, be;
        ae = {{32{a[31]}}, a};
        be = {{32{b[31]}}, b};
        return ae * be;
    endfunction

    // Unsigned 32x32 -> 64 product, returned as {hi, lo}.
    function automatic logic [63:0] mul_u(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ae, be;
        ae = {32'd0, a};
        be = {32'd0, b};
        return ae * be;
    endfunction

    // Signed divide returning {remainder, quotient}; the single overflow case
    // (most-negative / -1) is pinned to quotient = most-negative, remainder = 0.
    function automatic logic [63:0] div_s(input logic signed [31:0] a,
                                          input logic signed [31:0] b);
        logic signed [31:0] q, r;
        if (a == $signed(32'h8000_0000) && b == -32'sd1) begin
            q = a;
            r = '0;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Unsigned divide returning {remainder, quotient}.
    function automatic logic [63:0] div_u(input logic [31:0] a, input logic [31:0] b);
        return {a % b, a / b};
    endfunction

    assign launch = Start && (state == IDLE) &&
                    (MDUOp == OP_MULT || MDUOp == OP_MULTU ||
                     MDUOp == OP_DIV  || MDUOp == OP_DIVU);
    assign is_mul = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU);
    assign Busy   = (state == RUN);

    // Result selection; a zero divisor re-latches current HI/LO so they end unchanged.
    always_comb begin
        res_hi = HI;
        res_lo = LO;
        case (MDUOp)
            OP_MULT:  {res_hi, res_lo} = mul_s(A, B);
            OP_MULTU: {res_hi, res_lo} = mul_u(A, B);
            OP_DIV:   if (B != 32'd0) {res_hi, res_lo} = div_s(A, B);
            OP_DIVU:  if (B != 32'd0) {res_hi, res_lo} = div_u(A, B);
            default:  ;
        endcase
    end

    // FSM state and latency counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: launch loads the countdown, RUN counts down to zero.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: if (launch) begin
                state_nxt = RUN;
                cnt_nxt   = is_mul ? CNT_W'(MUL_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);
            end
            RUN: if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);
                 else           state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operands are consumed only at the launch edge; the result waits here.
    always_ff @(posedge clk) begin
        if (launch) begin
            hi_tmp <= res_hi;
            lo_tmp <= res_lo;
        end
    end

    // Architectural HI/LO: commit on the final RUN cycle, or mthi/mtlo when idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            HI <= '0;
            LO <= '0;
        end else if (state == RUN) begin
            if (cnt == '0) begin
                HI <= hi_tmp;
                LO <= lo_tmp;
            end
        end else if (!Start) begin
            if (MDUOp == OP_MTHI) HI <= A;
            if (MDUOp == OP_MTLO) LO <= A;
        end
    end

    // Read mux for mfhi/mflo.
    always_comb begin
        MDOut = '0;
        if (MDUOp == OP_MFHI) MDOut = HI;
        else if (MDUOp == OP_MFLO) MDOut = LO;
    end

endmodule
